// File: rtl/uart_mem_loader.sv
// Steers debug-unit programming words into instruction or data memory with registered write ports.
// Optional running word checksum is enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_mem_loader #(
  parameter int ISA_WIDTH  = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   uart_addr,
  input  logic [ISA_WIDTH-1:0]  uart_data,
  input  logic                  uart_write_enable,
  input  logic                  uart_complete,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [ISA_WIDTH-1:0]  imem_wdata,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [ISA_WIDTH-1:0]  dmem_wdata,
  output logic                  load_busy,
  output logic                  load_done,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  seq_error,
  output logic                  unarmed_error,
  output logic [ISA_WIDTH-1:0]  checksum
);

  localparam int AW1 = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ARMED, LOAD, DONE} state_t;

  state_t         state, next_state;
  logic [AW1-1:0] expected_addr;
  logic [AW1-1:0] next_expected;
  logic           is_marker;
  logic           loading;
  logic           arm;
  logic           accept_write;
  logic           unarmed_strobe;

  assign is_marker      = &uart_addr;
  assign loading        = (state == ARMED) || (state == LOAD);
  assign arm            = uart_write_enable && is_marker;
  assign accept_write   = uart_write_enable && !is_marker && loading;
  assign unarmed_strobe = uart_write_enable && !is_marker && !loading;
  assign next_expected  = expected_addr + AW1'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // DONE lasts one cycle; a strobe landing there is treated as if already back in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (arm) next_state = ARMED;
      ARMED, LOAD: begin
        if (uart_complete)     next_state = DONE;
        else if (arm)          next_state = ARMED;
        else if (accept_write) next_state = LOAD;
      end
      DONE:        next_state = arm ? ARMED : IDLE;
      default:     next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_addr <= '1;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      load_busy     <= 1'b0;
      load_done     <= 1'b0;
      word_count    <= '0;
      seq_error     <= 1'b0;
      unarmed_error <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      dmem_we   <= 1'b0;
      load_done <= (next_state == DONE);
      load_busy <= (next_state == ARMED) || (next_state == LOAD);
      if (arm) begin
        expected_addr <= '1;
        word_count    <= '0;
        seq_error     <= 1'b0;
      end else if (accept_write) begin
        // Address MSB picks the memory; the write still happens on a sequence break.
        if (uart_addr[ADDR_WIDTH]) begin
          dmem_we    <= 1'b1;
          dmem_addr  <= uart_addr[ADDR_WIDTH-1:0];
          dmem_wdata <= uart_data;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= uart_addr[ADDR_WIDTH-1:0];
          imem_wdata <= uart_data;
        end
        if (uart_addr != next_expected) seq_error <= 1'b1;
        expected_addr <= uart_addr;
        if (word_count != '1) word_count <= word_count + CNT_WIDTH'(1);
      end
      if (unarmed_strobe) unarmed_error <= 1'b1;
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            checksum <= '0;
    else if (arm)          checksum <= '0;
    else if (accept_write) checksum <= checksum + uart_data;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomised and directed bench for uart_mem_loader against a transaction-level reference model.
// Honours UART_LOADER_CHECKSUM_EN when predicting the checksum output.
module tb_uart_mem_loader;

  localparam logic [14:0] MARKER = 15'h7fff;

  logic        clk;
  logic        rst_n;
  logic [14:0] uart_addr;
  logic [31:0] uart_data;
  logic        uart_write_enable;
  logic        uart_complete;
  logic        imem_we;
  logic [13:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        load_busy;
  logic        load_done;
  logic [15:0] word_count;
  logic        seq_error;
  logic        unarmed_error;
  logic [31:0] checksum;

  int tests_run;
  int tests_failed;

  // Reference model: what the loader should be showing after the most recent clock edge.
  bit          m_loading;
  logic [14:0] m_next_addr;
  int          m_count;
  bit          m_seq, m_unarmed, m_busy, m_done, m_iwe, m_dwe;
  logic [31:0] m_sum, m_iwdata, m_dwdata;
  logic [13:0] m_iaddr, m_daddr;

  uart_mem_loader dut (
    .clk(clk), .rst_n(rst_n),
    .uart_addr(uart_addr), .uart_data(uart_data),
    .uart_write_enable(uart_write_enable), .uart_complete(uart_complete),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .load_busy(load_busy), .load_done(load_done), .word_count(word_count),
    .seq_error(seq_error), .unarmed_error(unarmed_error), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef UART_LOADER_CHECKSUM_EN
    return s;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    m_loading = 0; m_next_addr = 15'd0; m_count = 0;
    m_seq = 0; m_unarmed = 0; m_busy = 0; m_done = 0; m_iwe = 0; m_dwe = 0;
    m_sum = 0; m_iwdata = 0; m_dwdata = 0; m_iaddr = 0; m_daddr = 0;
  endtask

  // One clock of stimulus; returns #1 after the edge with the model advanced.
  task automatic drive_cycle(input bit we, input logic [14:0] addr, input logic [31:0] data,
                             input bit comp);
    bit was_loading;
    uart_write_enable = we; uart_addr = addr; uart_data = data; uart_complete = comp;
    was_loading = m_loading;
    m_iwe = 0; m_dwe = 0; m_done = 0;
    if (we && addr == MARKER) begin
      m_loading = 1; m_count = 0; m_seq = 0; m_sum = 0; m_next_addr = 15'd0;
    end else if (we) begin
      if (m_loading) begin
        if (addr != m_next_addr) m_seq = 1;
        m_next_addr = addr + 15'd1;
        if (m_count < 65535) m_count = m_count + 1;
        m_sum = m_sum + data;
        if (addr[14]) begin m_dwe = 1; m_daddr = addr[13:0]; m_dwdata = data; end
        else          begin m_iwe = 1; m_iaddr = addr[13:0]; m_iwdata = data; end
      end else begin
        m_unarmed = 1;
      end
    end
    if (comp && was_loading) begin m_loading = 0; m_done = 1; end
    m_busy = m_loading;
    @(posedge clk);
    #1;
    uart_write_enable = 0; uart_addr = '0; uart_data = '0; uart_complete = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; uart_write_enable = 0; uart_addr = '0; uart_data = '0; uart_complete = 0;
    model_reset();
    #3;
    tests_run++; if ({imem_we, dmem_we, load_busy, load_done} !== 4'b0) begin tests_failed++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000", {imem_we, dmem_we, load_busy, load_done}); end
    tests_run++; if ({imem_addr, dmem_addr} !== 28'h0) begin tests_failed++;
      $display("[TB] FAIL reset_addrs: got %h expected 0", {imem_addr, dmem_addr}); end
    tests_run++; if (word_count !== 16'h0 || seq_error !== 1'b0 || unarmed_error !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_status: got cnt %h seq %b un %b expected 0",
                               word_count, seq_error, unarmed_error); end
    tests_run++; if (checksum !== 32'h0 || imem_wdata !== 32'h0 || dmem_wdata !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_data: got sum %h iw %h dw %h expected 0",
                               checksum, imem_wdata, dmem_wdata); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_load();
    drive_cycle(1, MARKER, 32'h0, 0);
    tests_run++; if (load_busy !== 1'b1 || imem_we !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL arm_busy: got busy %b iwe %b expected 1 0", load_busy, imem_we); end
    drive_cycle(1, 15'd0, 32'hDEADBEEF, 0);
    tests_run++; if (imem_we !== 1'b1 || imem_addr !== 14'd0 || imem_wdata !== 32'hDEADBEEF) begin
      tests_failed++; $display("[TB] FAIL basic_w0: got we %b addr %h data %h expected 1 0 deadbeef",
                               imem_we, imem_addr, imem_wdata); end
    drive_cycle(1, 15'd1, 32'h00000013, 0);
    tests_run++; if (imem_we !== 1'b1 || imem_addr !== 14'd1 || imem_wdata !== 32'h13 || dmem_we !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL basic_w1: got we %b addr %h data %h dwe %b expected 1 1 13 0",
                               imem_we, imem_addr, imem_wdata, dmem_we); end
    drive_cycle(0, 15'd0, 32'h0, 1);
    tests_run++; if (load_done !== 1'b1 || load_busy !== 1'b0 || imem_we !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL basic_done: got done %b busy %b iwe %b expected 1 0 0", load_done, load_busy, imem_we); end
    tests_run++; if (word_count !== 16'd2 || seq_error !== 1'b0 || unarmed_error !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL basic_status: got cnt %0d seq %b un %b expected 2 0 0",
                               word_count, seq_error, unarmed_error); end
    tests_run++; if (checksum !== exp_sum(32'hDEADBF02)) begin tests_failed++;
      $display("[TB] FAIL basic_checksum: got %h expected %h", checksum, exp_sum(32'hDEADBF02)); end
    drive_cycle(0, 15'd0, 32'h0, 0);
    tests_run++; if (load_done !== 1'b0 || word_count !== 16'd2) begin tests_failed++;
      $display("[TB] FAIL basic_hold: got done %b cnt %0d expected 0 2", load_done, word_count); end
  endtask

  task automatic test_dmem_select();
    drive_cycle(1, MARKER, 32'h0, 0);
    drive_cycle(1, {1'b1, 14'd5}, 32'h12345678, 0);
    tests_run++; if (dmem_we !== 1'b1 || dmem_addr !== 14'd5 || dmem_wdata !== 32'h12345678) begin
      tests_failed++; $display("[TB] FAIL dmem_write: got we %b addr %h data %h expected 1 5 12345678",
                               dmem_we, dmem_addr, dmem_wdata); end
    tests_run++; if (imem_we !== 1'b0 || seq_error !== 1'b1) begin tests_failed++;
      $display("[TB] FAIL dmem_flags: got iwe %b seq %b expected 0 1", imem_we, seq_error); end
    drive_cycle(0, 15'd0, 32'h0, 0);
    tests_run++; if (dmem_we !== 1'b0 || dmem_addr !== 14'd5) begin tests_failed++;
      $display("[TB] FAIL dmem_single_pulse: got we %b addr %h expected 0 5", dmem_we, dmem_addr); end
  endtask

  task automatic test_unarmed();
    drive_cycle(0, 15'd0, 32'h0, 1);
    drive_cycle(0, 15'd0, 32'h0, 0);
    drive_cycle(1, 15'd3, 32'hCAFEF00D, 0);
    tests_run++; if (imem_we !== 1'b0 || dmem_we !== 1'b0 || unarmed_error !== 1'b1 || load_busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL unarmed: got iwe %b dwe %b un %b busy %b expected 0 0 1 0",
                               imem_we, dmem_we, unarmed_error, load_busy); end
    drive_cycle(0, 15'd0, 32'h0, 1);
    tests_run++; if (load_done !== 1'b0 || imem_addr !== 14'd1) begin tests_failed++;
      $display("[TB] FAIL idle_complete: got done %b iaddr %h expected 0 1", load_done, imem_addr); end
  endtask

  task automatic test_complete_with_write();
    drive_cycle(1, MARKER, 32'h0, 0);
    drive_cycle(1, 15'd0, 32'h11111111, 0);
    drive_cycle(1, 15'd1, 32'h22222222, 1);
    tests_run++; if (imem_we !== 1'b1 || imem_addr !== 14'd1 || imem_wdata !== 32'h22222222) begin
      tests_failed++; $display("[TB] FAIL cw_write: got we %b addr %h data %h expected 1 1 22222222",
                               imem_we, imem_addr, imem_wdata); end
    tests_run++; if (load_done !== 1'b1 || word_count !== 16'd2 || load_busy !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL cw_done: got done %b cnt %0d busy %b expected 1 2 0", load_done, word_count, load_busy); end
    drive_cycle(0, 15'd0, 32'h0, 0);
    tests_run++; if (load_done !== 1'b0 || imem_we !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL cw_after: got done %b iwe %b expected 0 0", load_done, imem_we); end
  endtask

  task automatic test_rearm();
    drive_cycle(1, MARKER, 32'h0, 0);
    drive_cycle(1, 15'd0, 32'hAAAA0000, 0);
    drive_cycle(1, MARKER, 32'h0, 0);
    tests_run++; if (imem_we !== 1'b0 || word_count !== 16'd0 || load_busy !== 1'b1) begin tests_failed++;
      $display("[TB] FAIL rearm_clear: got iwe %b cnt %0d busy %b expected 0 0 1", imem_we, word_count, load_busy); end
    drive_cycle(1, 15'd0, 32'h0000BBBB, 0);
    tests_run++; if (word_count !== 16'd1 || seq_error !== 1'b0 || checksum !== exp_sum(32'h0000BBBB)) begin
      tests_failed++; $display("[TB] FAIL rearm_count: got cnt %0d seq %b sum %h expected 1 0 %h",
                               word_count, seq_error, checksum, exp_sum(32'h0000BBBB)); end
  endtask

  task automatic test_reset_mid_load();
    drive_cycle(1, MARKER, 32'h0, 0);
    drive_cycle(1, 15'd0, 32'h55555555, 0);
    #2 rst_n = 0;
    model_reset();
    #1;
    tests_run++; if (imem_we !== 1'b0 || load_busy !== 1'b0 || word_count !== 16'd0 || imem_wdata !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL async_reset: got iwe %b busy %b cnt %0d iw %h expected 0 0 0 0",
                               imem_we, load_busy, word_count, imem_wdata); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    drive_cycle(1, 15'd1, 32'h66666666, 0);
    tests_run++; if (unarmed_error !== 1'b1 || imem_we !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL post_reset_unarmed: got un %b iwe %b expected 1 0", unarmed_error, imem_we); end
  endtask

  task automatic test_saturation();
    drive_cycle(1, MARKER, 32'h0, 0);
    for (int i = 0; i < 65534; i++) drive_cycle(1, 15'(i % 1024), 32'h1, 0);
    tests_run++; if (word_count !== 16'hFFFE) begin tests_failed++;
      $display("[TB] FAIL sat_below: got %h expected fffe", word_count); end
    for (int i = 0; i < 4; i++) drive_cycle(1, 15'(i), 32'h1, 0);
    tests_run++; if (word_count !== 16'hFFFF) begin tests_failed++;
      $display("[TB] FAIL sat_hold: got %h expected ffff", word_count); end
  endtask

  task automatic test_random();
    int r;
    logic [14:0] a;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      a = ($urandom_range(0, 9) < 7 && m_next_addr != MARKER) ? m_next_addr : 15'($urandom_range(0, 32766));
      if (r < 8)       drive_cycle(1, MARKER, 32'h0, 0);
      else if (r < 14) drive_cycle(r[0], a, $urandom, 1);
      else if (r < 22) drive_cycle(0, 15'd0, 32'h0, 0);
      else             drive_cycle(1, a, $urandom, 0);
      tests_run++; if (imem_we !== m_iwe || dmem_we !== m_dwe) begin tests_failed++;
        $display("[TB] FAIL rnd_we[%0d]: got %b%b expected %b%b", i, imem_we, dmem_we, m_iwe, m_dwe); end
      tests_run++; if (imem_addr !== m_iaddr || imem_wdata !== m_iwdata) begin tests_failed++;
        $display("[TB] FAIL rnd_imem[%0d]: got %h %h expected %h %h", i, imem_addr, imem_wdata, m_iaddr, m_iwdata); end
      tests_run++; if (dmem_addr !== m_daddr || dmem_wdata !== m_dwdata) begin tests_failed++;
        $display("[TB] FAIL rnd_dmem[%0d]: got %h %h expected %h %h", i, dmem_addr, dmem_wdata, m_daddr, m_dwdata); end
      tests_run++; if (load_busy !== m_busy || load_done !== m_done) begin tests_failed++;
        $display("[TB] FAIL rnd_fsm[%0d]: got busy %b done %b expected %b %b", i, load_busy, load_done, m_busy, m_done); end
      tests_run++; if (word_count !== 16'(m_count) || seq_error !== m_seq || unarmed_error !== m_unarmed) begin
        tests_failed++; $display("[TB] FAIL rnd_status[%0d]: got %0d %b %b expected %0d %b %b", i,
                                 word_count, seq_error, unarmed_error, m_count, m_seq, m_unarmed); end
      tests_run++; if (checksum !== exp_sum(m_sum)) begin tests_failed++;
        $display("[TB] FAIL rnd_checksum[%0d]: got %h expected %h", i, checksum, exp_sum(m_sum)); end
      if (r >= 8 && r < 14) drive_cycle(0, 15'd0, 32'h0, 0);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic_load();
    test_dmem_select();
    test_unarmed();
    test_complete_with_write();
    test_rearm();
    test_reset_mid_load();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
